// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_FILL,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int HDR_BYTES  = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler used for both the length header and
// the payload words. word_valid_o is combinational in the cycle of the
// fourth accepted byte so the caller can register the finished word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] acc_q, acc_d;

  // Earlier bytes shift down so the first byte lands in bits 7:0.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (byte_en_i) begin
      cnt_d = cnt_q + 2'd1;
      acc_d = {byte_i, acc_q[23:8]};
    end
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end
  end

  // Byte counter and partial-word register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign word_valid_o = byte_en_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = {byte_i, acc_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length header and N little-endian words, writes
// them into instruction memory, zero-fills the rest, holds the CPU in reset
// for RESET_HOLD cycles after the last write, then starts it.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte over the payload that must match before the CPU is released.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              cpu_rst_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = $clog2(RESET_HOLD + 2);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(IMEM_DEPTH - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d, wl_q, wl_d, fill_q, fill_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                busy_q, busy_d, we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                ready, hs, pk_valid;
  logic [31:0]         pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // A full memory needs no zero-fill pass.
  function automatic state_e fill_or_hold(input logic [CNT_W-1:0] n);
    return (n == DEPTH_C) ? ST_HOLD : ST_FILL;
  endfunction

  byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (state_d != state_q),
    .byte_en_i    (hs && (state_q == ST_LEN || state_q == ST_DATA)),
    .byte_i       (byte_data_i),
    .word_valid_o (pk_valid),
    .word_o       (pk_word)
  );

  assign hs = byte_valid_i && ready;

  // Next-state, write-port and counter logic.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wl_d    = wl_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    busy_d  = busy_q | hs;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    ready   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_LEN: begin
        ready = !rst_i;
        if (pk_valid) begin
          n_d    = pk_word[CNT_W-1:0];
          fill_d = pk_word[CNT_W-1:0];
          if (pk_word > 32'(IMEM_DEPTH)) begin
            state_d = ST_ERR;
          end else if (pk_word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_FILL;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        ready = !rst_i;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (hs) csum_d = csum_q ^ byte_data_i;
`endif
        if (pk_valid) begin
          we_d   = 1'b1;
          addr_d = wl_q[ADDR_W-1:0];
          data_d = pk_word;
          wl_d   = wl_q + CNT_W'(1);
          if (wl_q + CNT_W'(1) == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = fill_or_hold(n_q);
`endif
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        ready = !rst_i;
        if (hs) state_d = (byte_data_i == csum_q) ? fill_or_hold(n_q) : ST_ERR;
      end
`endif
      ST_FILL: begin
        we_d   = 1'b1;
        addr_d = fill_q[ADDR_W-1:0];
        data_d = '0;
        fill_d = fill_q + CNT_W'(1);
        if (fill_q == LAST_C) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RESET_HOLD)) state_d = ST_RUN;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_LEN;
      n_q     <= '0;
      wl_q    <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wl_q    <= wl_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign byte_ready_o   = ready;
  assign imem_we_o      = we_q;
  assign imem_addr_o    = addr_q;
  assign imem_data_o    = data_q;
  assign cpu_rst_o      = (state_q != ST_RUN);
  assign cpu_start_o    = (state_q == ST_RUN);
  assign done_o         = (state_q == ST_RUN);
  assign err_o          = (state_q == ST_ERR);
  assign busy_o         = busy_q && (state_q != ST_RUN) && (state_q != ST_ERR);
  assign words_loaded_o = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level model pushes the expected
// memory writes; a monitor pops and compares each write the DUT issues.
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int RH    = 4;

  logic          clk = 1'b0;
  logic          rst_i, byte_valid_i;
  logic [7:0]    byte_data_i;
  logic          byte_ready_o, imem_we_o, cpu_rst_o, cpu_start_o;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_data_o;
  logic [AW:0]   words_loaded_o;

  typedef logic [7:0] bq_t[$];

  logic [39:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;

  imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .RESET_HOLD(RH)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .byte_valid_i   (byte_valid_i),
    .byte_data_i    (byte_data_i),
    .byte_ready_o   (byte_ready_o),
    .imem_we_o      (imem_we_o),
    .imem_addr_o    (imem_addr_o),
    .imem_data_o    (imem_data_o),
    .cpu_rst_o      (cpu_rst_o),
    .cpu_start_o    (cpu_start_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .words_loaded_o (words_loaded_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of the queue.
  always @(negedge clk) begin
    if (imem_we_o === 1'b1) begin
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h", imem_addr_o, imem_data_o);
      end else begin
        chk("write", {imem_addr_o, imem_data_o}, exp_q.pop_front());
      end
    end
  end

  // Reference model: interprets the byte stream and queues the writes it implies.
  task automatic model(input bq_t s, output bit ok, output int nw);
    logic [31:0] n;
    logic [7:0]  x;
    n  = {s[3], s[2], s[1], s[0]};
    ok = 1'b0;
    nw = 0;
    x  = 8'h00;
    if (n > DEPTH) return;
    for (int k = 0; k < int'(n); k++)
      exp_q.push_back({8'(k), s[4*k+7], s[4*k+6], s[4*k+5], s[4*k+4]});
    nw = int'(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int i = 4; i < 4 + 4 * int'(n); i++) x = x ^ s[i];
    if (s[4 + 4 * int'(n)] != x) return;
`endif
    for (int a = int'(n); a < DEPTH; a++) exp_q.push_back({8'(a), 32'h0});
    ok = 1'b1;
  endtask

  function automatic logic [7:0] payload_xor(input bq_t s);
    logic [7:0] x = 8'h00;
    for (int i = 4; i < s.size(); i++) x = x ^ s[i];
    return x;
  endfunction

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_ready", byte_ready_o, 1'b0);
    chk("rst_we", imem_we_o, 1'b0);
    chk("rst_addr", imem_addr_o, '0);
    chk("rst_data", imem_data_o, '0);
    chk("rst_cpu_rst", cpu_rst_o, 1'b1);
    chk("rst_start", cpu_start_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_words", words_loaded_o, '0);
    rst_i = 1'b0;
  endtask

  // Offers bytes from posedge+1; a byte counts when valid && ready before the edge.
  task automatic send_bytes(input bq_t s, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < s.size() && guard < 5000) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        byte_valid_i = 1'b0;
        byte_data_i  = 8'($urandom);
      end else begin
        byte_valid_i = 1'b1;
        byte_data_i  = s[i];
      end
      @(negedge clk);
      if (byte_valid_i && byte_ready_o) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    byte_valid_i = 1'b0;
    byte_data_i  = 8'($urandom);
    chk("send_complete", i, s.size());
  endtask

  task automatic finish_load(input string nm, input bit ok, input int nw);
    int t = 0;
    int bad = 0;
    @(negedge clk);
    while (!(done_o === 1'b1 || err_o === 1'b1) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_timeout"}, t < 4000, 1'b1);
    if (ok) chk({nm, "_hold_gap"}, cyc - last_we_cyc, RH + 1);
    chk({nm, "_done"}, done_o, ok);
    chk({nm, "_err"}, err_o, !ok);
    chk({nm, "_start"}, cpu_start_o, ok);
    chk({nm, "_cpu_rst"}, cpu_rst_o, !ok);
    chk({nm, "_busy"}, busy_o, 1'b0);
    chk({nm, "_words"}, words_loaded_o, nw);
    chk({nm, "_writes_left"}, exp_q.size(), 0);
    repeat (100) begin
      byte_valid_i = 1'b1;
      byte_data_i  = 8'($urandom);
      @(negedge clk);
      if (byte_ready_o !== 1'b0 || cpu_start_o !== ok || cpu_rst_o !== !ok || err_o !== !ok)
        bad++;
    end
    byte_valid_i = 1'b0;
    chk({nm, "_terminal_stable"}, bad, 0);
    exp_q.delete();
  endtask

  task automatic run_case(input string nm, input bq_t s, input bit gaps);
    bit ok;
    int nw;
    logic [31:0] n;
    n = {s[3], s[2], s[1], s[0]};
    model(s, ok, nw);
    send_bytes(s, gaps);
    chk({nm, "_ready_drop"}, byte_ready_o, 1'b0);
    if (n > DEPTH) chk({nm, "_err_next_cycle"}, err_o, 1'b1);
    finish_load(nm, ok, nw);
  endtask

  initial begin
    bq_t s1, s0, sbig, sdb, sr, sp;
    int n;
    logic [31:0] w;
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;

    s1   = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00};
    s0   = '{8'h00, 8'h00, 8'h00, 8'h00};
    sbig = '{8'h01, 8'h01, 8'h00, 8'h00};
    sdb  = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef IMEM_LOADER_CHECKSUM_EN
    s1.push_back(payload_xor(s1));
    s0.push_back(8'h00);
    sdb.push_back(payload_xor(sdb));
`endif

    do_reset(3);
    run_case("two_words", s1, 1'b0);

    do_reset(2);
    run_case("empty", s0, 1'b0);

    do_reset(2);
    run_case("oversize", sbig, 1'b0);

    do_reset(2);
    run_case("backpressure", s1, 1'b1);

    // Abort after 6 accepted bytes, then load a fresh image.
    do_reset(2);
    sp = s1[0:5];
    send_bytes(sp, 1'b0);
    chk("midload_busy", busy_o, 1'b1);
    do_reset(1);
    run_case("after_abort", sdb, 1'b0);

    // Randomized images with random flow control.
    repeat (3) begin
      do_reset(2);
      n = $urandom_range(1, 6);
      sr = '{8'(n), 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) sr.push_back(w[8*b +: 8]);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      sr.push_back(payload_xor(sr));
`endif
      run_case("random", sr, 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset(2);
    sr = s1[0:11];
    sr.push_back(8'h40);
    run_case("bad_csum", sr, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Synthesizable boot loader that performs in hardware what the bench does at time zero: fills CPU instruction memory from a byte stream, zero-fills the unused words, then releases CPU reset and asserts start.
- Sits between a byte source (UART or host bridge) and the CPU's instruction-memory write port and rst_i/start_i inputs.
- Acts as the writer that feeds the CPU's instruction fetch path.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= IMEM_DEPTH.
- RESET_HOLD, 4, cycles that cpu_rst_o stays high after the last memory write.

Ports:
- clk_i  in  1  sole clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- byte_valid_i  in  1  source has a byte.
- byte_data_i  in  8  byte payload.
- byte_ready_o  out  1  loader accepts a byte; a transfer occurs when valid && ready.
- imem_we_o  out  1  instruction memory write strobe, one-cycle pulse per word.
- imem_addr_o  out  ADDR_W  word address.
- imem_data_o  out  32  write data.
- cpu_rst_o  out  1  drives CPU rst_i.
- cpu_start_o  out  1  drives CPU start_i.
- busy_o  out  1  load in progress.
- done_o  out  1  CPU released.
- err_o  out  1  sticky error.
- words_loaded_o  out  ADDR_W+1  count of payload words written.

Behaviour:
- Reset values while rst_i is high:
  - byte_ready_o=0, imem_we_o=0, imem_addr_o=0, imem_data_o=0.
  - cpu_rst_o=1, cpu_start_o=0, busy_o=0, done_o=0, err_o=0, words_loaded_o=0.
  - State goes to LEN.
- Stream format, all little-endian:
  - 4-byte header N = number of instruction words.
  - Then N words of 4 bytes each; the first byte received is bits 7:0.
- States and transitions:
  - LEN: ready=1. After the 4th header byte: if N > IMEM_DEPTH, go to ERR; if N == 0, go to FILL; otherwise go to DATA. busy_o=1 from the first accepted byte onward.
  - DATA: ready=1. The cycle after each 4th byte handshake, imem_we_o pulses with addr = word index and data = assembled word (latency 1). words_loaded_o increments on the same cycle. After word N-1, go to CHK if the feature is enabled, else FILL.
  - FILL: ready=0. Writes 0 to addresses N..IMEM_DEPTH-1, one per cycle with we=1 each cycle. If N == IMEM_DEPTH, zero cycles are spent here.
  - HOLD: cpu_rst_o=1 for exactly RESET_HOLD cycles, then go to RUN.
  - RUN: cpu_rst_o=0, cpu_start_o=1, done_o=1, busy_o=0, ready=0. Extra bytes are never accepted. Terminal until rst_i.
  - ERR: err_o=1, cpu_rst_o=1, ready=0, no writes. Sticky until rst_i.
- Boundary rules:
  - byte_data_i is ignored whenever valid or ready is low.
  - Gaps in valid may occur at any byte position; partial words are retained across gaps.
  - rst_i asserted mid-load aborts the load; memory words already written are left as-is. The next load restarts from LEN.
  - The header is compared as an unsigned 32-bit value; high bytes that are nonzero make N > IMEM_DEPTH and lead to ERR.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the N payload words, state CHK accepts one byte.
  - That byte must equal the XOR of all payload bytes; the header is excluded.
  - Match: go to FILL. Mismatch: go to ERR; words already written remain.
  - N == 0 still expects a checksum byte of 0x00.
- Disabled: no CHK state; ready drops right after the last payload byte.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (LEN, DATA, CHK, FILL, HOLD, RUN, ERR);
  - WORD_BYTES=4 and HDR_BYTES=4.
- Sub-module byte_packer:
  - 2-bit byte counter plus a 32-bit little-endian shift/assemble register;
  - emits a word_valid pulse with the word;
  - clear input used on state entry;
  - reused for both the header and the payload.

Test Plan:
- Load two words: stream 02 00 00 00 93 00 50 00 13 81 10 00, valid held high.
  - Writes addr0=0x00500093 and addr1=0x00108113.
  - Then 254 zero writes at addrs 2..255.
  - cpu_rst_o=1 for 4 further cycles, then cpu_start_o=1 and done_o=1 with words_loaded_o=2.
- Empty load: header 00 00 00 00.
  - 256 zero writes at addrs 0..255, then start.
  - words_loaded_o=0.
- Oversize header: 01 01 00 00 (N=257).
  - err_o=1 the cycle after the 4th byte.
  - No imem_we_o pulses; cpu_rst_o stays 1 and start stays 0 for 100 cycles.
- Backpressure: the first scenario's stream with valid toggled pseudo-randomly and garbage on byte_data_i while valid is low.
  - Identical write sequence and final outputs to the first scenario.
- Mid-load reset: rst_i pulsed for 1 cycle after 6 accepted bytes.
  - All outputs return to reset values.
  - A subsequent load 01 00 00 00 EF BE AD DE writes addr0=0xDEADBEEF and ends in RUN.
- With IMEM_LOADER_CHECKSUM_EN, first scenario's stream followed by a checksum byte:
  - 0x41 leads to normal start;
  - 0x40 gives err_o=1, no start, and addrs 0..1 still written.
